// File: rtl/sram_arbiter.sv
// Three-port (instruction, data, video) round-robin arbiter onto a 16-bit async SRAM.
// Each 32-bit word is moved as two halfword phases, high half first.
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    input  logic        v_req,
    input  logic [31:0] v_addr,
    output logic [31:0] v_rdata,
    output logic        v_ack,
    output logic        cpu_stall,
    output logic [22:0] sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        sram_we,
    output logic        sram_oe,
    output logic        sram_ce,
    output logic        sram_clk,
    output logic        sram_adv,
    output logic        sram_cre,
    output logic        sram_lb,
    output logic        sram_ub
);

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);
    localparam logic [1:0] OWN_I    = 2'd0;
    localparam logic [1:0] OWN_D    = 2'd1;
    localparam logic [1:0] OWN_V    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Returns {found, owner}; the search starts at the port after the last one granted.
    function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [2:0] reqs);
        logic [2:0] res;
        res = 3'b000;
        case (last)
            OWN_I: begin
                if (reqs[1])      res = {1'b1, OWN_D};
                else if (reqs[2]) res = {1'b1, OWN_V};
                else if (reqs[0]) res = {1'b1, OWN_I};
                else              res = 3'b000;
            end
            OWN_D: begin
                if (reqs[2])      res = {1'b1, OWN_V};
                else if (reqs[0]) res = {1'b1, OWN_I};
                else if (reqs[1]) res = {1'b1, OWN_D};
                else              res = 3'b000;
            end
            default: begin
                if (reqs[0])      res = {1'b1, OWN_I};
                else if (reqs[1]) res = {1'b1, OWN_D};
                else if (reqs[2]) res = {1'b1, OWN_V};
                else              res = 3'b000;
            end
        endcase
        return res;
    endfunction

    state_t      state_r;
    state_t      state_nx;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nx;
    logic [1:0]  last_r;
    logic [1:0]  owner_r;
    logic [21:0] addr_r;
    logic        we_r;
    logic [31:0] wdata_r;
    logic [15:0] hi_buf_r;
    logic [31:0] i_rdata_r;
    logic [31:0] d_rdata_r;
    logic [31:0] v_rdata_r;
    logic        i_ack_r;
    logic        d_ack_r;
    logic        v_ack_r;
    logic [22:0] sram_addr_r;
    logic        sram_we_r;
    logic        sram_oe_r;
    logic        sram_ce_r;
    logic        data_oe_r;
    logic [15:0] data_out_r;

    logic [2:0]  pick_s;
    logic        grant_s;
    logic [21:0] sel_addr_s;
    logic        sel_we_s;
    logic [21:0] cur_addr_s;
    logic        cur_we_s;
    logic [31:0] cur_wdata_s;
    logic        phase_s;
    logic        lo_s;
    logic        hi_last_s;
    logic        lo_last_s;
    logic [22:0] sram_addr_nx;
    logic        sram_we_nx;
    logic        sram_oe_nx;
    logic        sram_ce_nx;
    logic        data_oe_nx;
    logic [15:0] data_out_nx;
    logic        i_ack_nx;
    logic        d_ack_nx;
    logic        v_ack_nx;
    logic        unused_addr_bits_s;

    assign unused_addr_bits_s = ^{i_addr[31:24], i_addr[1:0], d_addr[31:24], d_addr[1:0],
                                  v_addr[31:24], v_addr[1:0]};

    // Request selection: round-robin winner and its address / direction.
    always_comb begin
        pick_s     = rr_pick(last_r, {v_req, d_req, i_req});
        sel_addr_s = v_addr[23:2];
        sel_we_s   = 1'b0;
        case (pick_s[1:0])
            OWN_I: begin
                sel_addr_s = i_addr[23:2];
                sel_we_s   = 1'b0;
            end
            OWN_D: begin
                sel_addr_s = d_addr[23:2];
                sel_we_s   = d_we;
            end
            default: begin
                sel_addr_s = v_addr[23:2];
                sel_we_s   = 1'b0;
            end
        endcase
    end

    // Transaction FSM next state and phase counter.
    always_comb begin
        state_nx  = state_r;
        cnt_nx    = cnt_r;
        grant_s   = 1'b0;
        hi_last_s = (state_r == ST_HI) && (cnt_r == LAST_CNT);
        lo_last_s = (state_r == ST_LO) && (cnt_r == LAST_CNT);
        case (state_r)
            ST_IDLE: begin
                if (pick_s[2]) begin
                    state_nx = ST_HI;
                    cnt_nx   = 4'd0;
                    grant_s  = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_HI: begin
                if (hi_last_s) begin
                    state_nx = ST_LO;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt_r + 4'd1;
                end
            end
            ST_LO: begin
                if (lo_last_s) begin
                    state_nx = ST_DONE;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt_r + 4'd1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                cnt_nx   = 4'd0;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Transaction attributes for the coming cycle: freshly granted or already latched.
    always_comb begin
        if (grant_s) begin
            cur_addr_s  = sel_addr_s;
            cur_we_s    = sel_we_s;
            cur_wdata_s = d_wdata;
        end else begin
            cur_addr_s  = addr_r;
            cur_we_s    = we_r;
            cur_wdata_s = wdata_r;
        end
    end

    // SRAM strobes and acks are computed one cycle ahead so they leave flops.
    always_comb begin
        phase_s      = (state_nx == ST_HI) || (state_nx == ST_LO);
        lo_s         = (state_nx == ST_LO);
        sram_ce_nx   = 1'b1;
        sram_oe_nx   = 1'b1;
        sram_we_nx   = 1'b1;
        data_oe_nx   = 1'b0;
        data_out_nx  = 16'h0000;
        sram_addr_nx = sram_addr_r;
        if (phase_s) begin
            sram_ce_nx   = 1'b0;
            sram_addr_nx = {cur_addr_s, lo_s};
            if (cur_we_s) begin
                data_oe_nx  = 1'b1;
                data_out_nx = lo_s ? cur_wdata_s[15:0] : cur_wdata_s[31:16];
                // Last cycle of the phase releases WE while address and data still hold.
                sram_we_nx  = (cnt_nx == LAST_CNT);
            end else begin
                sram_oe_nx = 1'b0;
            end
        end else begin
            sram_addr_nx = sram_addr_r;
        end
        i_ack_nx = (state_nx == ST_DONE) && (owner_r == OWN_I);
        d_ack_nx = (state_nx == ST_DONE) && (owner_r == OWN_D);
        v_ack_nx = (state_nx == ST_DONE) && (owner_r == OWN_V);
    end

    // FSM state, phase counter, round-robin pointer and latched request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            last_r  <= OWN_V;
            owner_r <= OWN_I;
            addr_r  <= 22'd0;
            we_r    <= 1'b0;
            wdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            if (grant_s) begin
                last_r  <= pick_s[1:0];
                owner_r <= pick_s[1:0];
                addr_r  <= sel_addr_s;
                we_r    <= sel_we_s;
                wdata_r <= d_wdata;
            end
        end
    end

    // Read capture; the owner's word is published only once both halves are in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_buf_r  <= 16'h0000;
            i_rdata_r <= 32'h0000_0000;
            d_rdata_r <= 32'h0000_0000;
            v_rdata_r <= 32'h0000_0000;
        end else begin
            if (hi_last_s && !we_r) begin
                hi_buf_r <= sram_data;
            end
            if (lo_last_s && !we_r) begin
                case (owner_r)
                    OWN_I:   i_rdata_r <= {hi_buf_r, sram_data};
                    OWN_D:   d_rdata_r <= {hi_buf_r, sram_data};
                    default: v_rdata_r <= {hi_buf_r, sram_data};
                endcase
            end
        end
    end

    // Output registers for the SRAM pins and completion pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sram_addr_r <= 23'd0;
            sram_we_r   <= 1'b1;
            sram_oe_r   <= 1'b1;
            sram_ce_r   <= 1'b1;
            data_oe_r   <= 1'b0;
            data_out_r  <= 16'h0000;
            i_ack_r     <= 1'b0;
            d_ack_r     <= 1'b0;
            v_ack_r     <= 1'b0;
        end else begin
            sram_addr_r <= sram_addr_nx;
            sram_we_r   <= sram_we_nx;
            sram_oe_r   <= sram_oe_nx;
            sram_ce_r   <= sram_ce_nx;
            data_oe_r   <= data_oe_nx;
            data_out_r  <= data_out_nx;
            i_ack_r     <= i_ack_nx;
            d_ack_r     <= d_ack_nx;
            v_ack_r     <= v_ack_nx;
        end
    end

    assign sram_data = data_oe_r ? data_out_r : 16'hzzzz;
    assign sram_addr = sram_addr_r;
    assign sram_we   = sram_we_r;
    assign sram_oe   = sram_oe_r;
    assign sram_ce   = sram_ce_r;
    assign sram_clk  = 1'b0;
    assign sram_adv  = 1'b0;
    assign sram_cre  = 1'b0;
    assign sram_lb   = 1'b0;
    assign sram_ub   = 1'b0;

    assign i_rdata = i_rdata_r;
    assign d_rdata = d_rdata_r;
    assign v_rdata = v_rdata_r;
    assign i_ack   = i_ack_r;
    assign d_ack   = d_ack_r;
    assign v_ack   = v_ack_r;

    // Stall is combinational so the ack cycle itself already releases the CPU.
    assign cpu_stall = (i_req & ~i_ack_r) | (d_req & ~d_ack_r);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (ACCESS_CYCLES=3) with a small async 16-bit SRAM model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, v_req;
    logic [31:0] i_addr, d_addr, d_wdata, v_addr;
    logic [31:0] i_rdata, d_rdata, v_rdata;
    logic        i_ack, d_ack, v_ack, cpu_stall;
    logic [22:0] sram_addr;
    wire  [15:0] sram_data;
    logic        sram_we, sram_oe, sram_ce;
    logic        sram_clk, sram_adv, sram_cre, sram_lb, sram_ub;

    logic [15:0] mem [0:1023];
    int total = 0;
    int bad   = 0;

    sram_arbiter #(.ACCESS_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .v_req(v_req), .v_addr(v_addr), .v_rdata(v_rdata), .v_ack(v_ack),
        .cpu_stall(cpu_stall),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_we(sram_we), .sram_oe(sram_oe), .sram_ce(sram_ce),
        .sram_clk(sram_clk), .sram_adv(sram_adv), .sram_cre(sram_cre),
        .sram_lb(sram_lb), .sram_ub(sram_ub)
    );

    always #5 clk = ~clk;

    // Async SRAM: drives on CE&OE low with WE high; latches on WE rising edge.
    assign sram_data = (sram_ce === 1'b0 && sram_oe === 1'b0 && sram_we === 1'b1)
                       ? mem[sram_addr[9:0]] : 16'hzzzz;

    always @(posedge sram_we) begin
        if (sram_ce === 1'b0) mem[sram_addr[9:0]] <= sram_data;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        total++; if ({i_ack, d_ack, v_ack} !== 3'b000) begin bad++; $display("FAIL reset_acks: got %b want 000", {i_ack, d_ack, v_ack}); end
        total++; if ({i_rdata, d_rdata, v_rdata} !== 96'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata, v_rdata}); end
        total++; if ({sram_we, sram_oe, sram_ce} !== 3'b111) begin bad++; $display("FAIL reset_strobes: got %b want 111", {sram_we, sram_oe, sram_ce}); end
        total++; if (sram_addr !== 23'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
        total++; if ({sram_clk, sram_adv, sram_cre, sram_lb, sram_ub} !== 5'b00000) begin bad++; $display("FAIL tied_pins: got %b want 00000", {sram_clk, sram_adv, sram_cre, sram_lb, sram_ub}); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
        rst = 1'b1;
    endtask

    task automatic test_single_read;
        int acks = 0;
        int ack_cyc = -1;
        logic [31:0] rd = 32'h0;
        logic stall_at_ack = 1'b1;
        tick;
        i_req = 1'b1; i_addr = 32'h0000_0100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin
                total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rd_stall_pending: got %b want 1", cpu_stall); end
            end
            if (c == 1) begin
                total++; if (sram_addr !== 23'h80) begin bad++; $display("FAIL rd_hi_addr: got %h want 80", sram_addr); end
                total++; if ({sram_ce, sram_oe, sram_we} !== 3'b001) begin bad++; $display("FAIL rd_strobes: got %b want 001", {sram_ce, sram_oe, sram_we}); end
            end
            if (c == 4) begin
                total++; if (sram_addr !== 23'h81) begin bad++; $display("FAIL rd_lo_addr: got %h want 81", sram_addr); end
            end
            if (i_ack === 1'b1) begin
                acks++;
                if (ack_cyc < 0) begin ack_cyc = c; rd = i_rdata; stall_at_ack = cpu_stall; end
                i_req = 1'b0;
            end
        end
        total++; if (acks !== 1) begin bad++; $display("FAIL rd_ack_count: got %0d want 1", acks); end
        total++; if (ack_cyc !== 7) begin bad++; $display("FAIL rd_latency: got %0d want 7", ack_cyc); end
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL rd_data: got %h want 12345678", rd); end
        total++; if (stall_at_ack !== 1'b0) begin bad++; $display("FAIL rd_stall_at_ack: got %b want 0", stall_at_ack); end
        total++; if (i_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_hold: got %h want 12345678", i_rdata); end
    endtask

    task automatic test_write;
        int acks = 0;
        int ack_cyc = -1;
        int we_hi = 0;
        int we_lo = 0;
        int we_other = 0;
        logic [31:0] rd_at_ack = 32'hFFFF_FFFF;
        tick;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sram_we === 1'b0) begin
                if (sram_addr === 23'h100)      we_hi++;
                else if (sram_addr === 23'h101) we_lo++;
                else                            we_other++;
            end
            if (c == 1) begin
                total++; if (sram_data !== 16'hDEAD) begin bad++; $display("FAIL wr_hi_data: got %h want dead", sram_data); end
                total++; if (sram_oe !== 1'b1) begin bad++; $display("FAIL wr_oe: got %b want 1", sram_oe); end
            end
            if (c == 4) begin
                total++; if (sram_data !== 16'hBEEF) begin bad++; $display("FAIL wr_lo_data: got %h want beef", sram_data); end
            end
            if (d_ack === 1'b1) begin
                acks++;
                if (ack_cyc < 0) begin ack_cyc = c; rd_at_ack = d_rdata; end
                d_req = 1'b0;
            end
        end
        total++; if (we_hi !== 2 || we_lo !== 2 || we_other !== 0) begin bad++; $display("FAIL wr_we_cycles: got hi=%0d lo=%0d other=%0d want 2 2 0", we_hi, we_lo, we_other); end
        total++; if (mem[256] !== 16'hDEAD || mem[257] !== 16'hBEEF) begin bad++; $display("FAIL wr_mem: got %h %h want dead beef", mem[256], mem[257]); end
        total++; if (acks !== 1 || ack_cyc !== 7) begin bad++; $display("FAIL wr_ack: got count=%0d cyc=%0d want 1 at 7", acks, ack_cyc); end
        total++; if (rd_at_ack !== 32'h0) begin bad++; $display("FAIL wr_rdata_unchanged: got %h want 0", rd_at_ack); end
    endtask

    task automatic test_read_back;
        int ack_cyc = -1;
        logic [31:0] rd = 32'h0;
        tick;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (d_ack === 1'b1) begin
                if (ack_cyc < 0) begin ack_cyc = c; rd = d_rdata; end
                d_req = 1'b0;
            end
        end
        total++; if (ack_cyc !== 7) begin bad++; $display("FAIL rb_latency: got %0d want 7", ack_cyc); end
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rb_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_code [0:3];
        int         exp_cyc  [0:3];
        logic [2:0] got_code [0:3];
        int         got_cyc  [0:3];
        int n = 0;
        int stall_low = 0;
        int multi = 0;
        exp_code[0] = 3'b001; exp_code[1] = 3'b010; exp_code[2] = 3'b100; exp_code[3] = 3'b001;
        exp_cyc[0] = 7; exp_cyc[1] = 15; exp_cyc[2] = 23; exp_cyc[3] = 31;
        for (int k = 0; k < 4; k++) begin got_code[k] = 3'b000; got_cyc[k] = -1; end
        rst = 1'b0;
        tick; tick;
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
        v_req = 1'b1; v_addr = 32'h0000_0300;
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c <= 31 && cpu_stall !== 1'b1) stall_low++;
            if ({v_ack, d_ack, i_ack} !== 3'b000) begin
                if ($countones({v_ack, d_ack, i_ack}) > 1) multi++;
                if (n < 4) begin got_code[n] = {v_ack, d_ack, i_ack}; got_cyc[n] = c; end
                n++;
            end
            if (c == 31) begin i_req = 1'b0; d_req = 1'b0; v_req = 1'b0; end
        end
        for (int k = 0; k < 4; k++) begin
            total++; if (got_code[k] !== exp_code[k] || got_cyc[k] !== exp_cyc[k]) begin bad++; $display("FAIL rr_grant%0d: got %b at %0d want %b at %0d", k, got_code[k], got_cyc[k], exp_code[k], exp_cyc[k]); end
        end
        total++; if (n !== 4 || multi !== 0) begin bad++; $display("FAIL rr_ack_total: got %0d multi=%0d want 4 multi=0", n, multi); end
        total++; if (stall_low !== 0) begin bad++; $display("FAIL rr_stall: got %0d low cycles want 0", stall_low); end
        total++; if ({i_rdata, d_rdata, v_rdata} !== {32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D}) begin bad++; $display("FAIL rr_rdata: got %h %h %h want 12345678 deadbeef cafef00d", i_rdata, d_rdata, v_rdata); end
    endtask

    task automatic test_reset_abort;
        int acks = 0;
        tick;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0208; d_wdata = 32'h1111_2222;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d_ack === 1'b1) acks++;
            if (c == 5) rst = 1'b0;
        end
        @(negedge clk);
        total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL abort_ack: got %b want 0", d_ack); end
        total++; if ({sram_we, sram_oe, sram_ce} !== 3'b111) begin bad++; $display("FAIL abort_strobes: got %b want 111", {sram_we, sram_oe, sram_ce}); end
        total++; if ({i_rdata, d_rdata, v_rdata} !== 96'h0) begin bad++; $display("FAIL abort_rdata: got %h want 0", {i_rdata, d_rdata, v_rdata}); end
        total++; if (sram_addr !== 23'h0) begin bad++; $display("FAIL abort_addr: got %h want 0", sram_addr); end
        d_req = 1'b0; d_we = 1'b0;
        tick;
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (d_ack === 1'b1) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL abort_no_ack: got %0d want 0", acks); end
    endtask

    task automatic test_video_pulse;
        int acks = 0;
        int ack_cyc = -1;
        logic [31:0] rd = 32'h0;
        tick;
        v_req = 1'b1; v_addr = 32'h0000_0300;
        @(posedge clk);
        #1;
        v_req = 1'b0;
        for (int c = 1; c < 26; c++) begin
            @(negedge clk);
            if (v_ack === 1'b1) begin
                acks++;
                if (ack_cyc < 0) begin ack_cyc = c; rd = v_rdata; end
            end
        end
        total++; if (acks !== 1 || ack_cyc !== 7) begin bad++; $display("FAIL vpulse_ack: got count=%0d cyc=%0d want 1 at 7", acks, ack_cyc); end
        total++; if (rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL vpulse_data: got %h want cafef00d", rd); end
    endtask

    task automatic test_idle;
        int bad_cyc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sram_ce !== 1'b1 || sram_we !== 1'b1 || cpu_stall !== 1'b0 || {i_ack, d_ack, v_ack} !== 3'b000) bad_cyc++;
        end
        total++; if (bad_cyc !== 0) begin bad++; $display("FAIL idle_quiet: got %0d bad cycles want 0", bad_cyc); end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] <= 16'h0000;
        mem[10'h080] <= 16'h1234;
        mem[10'h081] <= 16'h5678;
        mem[10'h180] <= 16'hCAFE;
        mem[10'h181] <= 16'hF00D;
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; v_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; v_addr = 32'h0; d_wdata = 32'h0;
        test_reset;
        test_single_read;
        test_write;
        test_read_back;
        test_round_robin;
        test_reset_abort;
        test_video_pulse;
        test_idle;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
